jzjpcc_fetch_buffer: RTL and testbench

Fetch-stage output buffer sitting directly downstream of the program counter and the synchronous instruction memory, and upstream of decode. It pairs each returned instruction word with the word address that fetched it, holds the pair in the IF/ID register, and absorbs the one in-flight memory read through a single-entry skid slot when decode stalls. It generates the PC stall and discards wrong-path fetches on a branch flush.

---
 rtl/jzjpcc_fetch_buffer.sv | 79 +++++++
 tb/tb_jzjpcc_fetch_buffer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_fetch_buffer.sv
// Fetch-stage IF/ID register with a one-entry skid slot.
// Pairs memory read data with its fetch address and absorbs the in-flight read on a decode stall.
module jzjpcc_fetch_buffer #(
    parameter logic [29:0] RESET_PC = 30'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [29:0] currentPC,
    input  logic [31:0] instructionIn,
    input  logic        decodeStall,
    input  logic        flush,
    output logic        pcStall,
    output logic [31:0] instructionOut,
    output logic [29:0] pcOut,
    output logic        instructionValid
);

    typedef struct packed {
        logic [31:0] instr;
        logic [29:0] pc;
    } fetch_t;

    logic [29:0] reqPC;
    logic        reqValid;
    fetch_t      arrival;
    fetch_t      outReg;
    logic        outValid;
    fetch_t      skidReg;
    logic        skidValid;
    logic        holdOut;

    assign arrival = '{instr: instructionIn, pc: reqPC};
    assign holdOut = decodeStall & outValid;
    assign pcStall = holdOut & ~flush;

    // Request tracking: data for reqPC shows up on instructionIn one cycle later
    always_ff @(posedge clock) begin
        if (reset) begin
            reqPC    <= RESET_PC;
            reqValid <= 1'b0;
        end else begin
            reqPC    <= currentPC;
            reqValid <= ~pcStall & ~flush;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            outReg    <= '0;
            outValid  <= 1'b0;
            skidReg   <= '0;
            skidValid <= 1'b0;
        end else if (flush) begin
            outValid  <= 1'b0;
            skidValid <= 1'b0;
        end else if (holdOut) begin
            if (reqValid) begin
                skidReg   <= arrival;
                skidValid <= 1'b1;
            end
        end else begin
            if (skidValid) begin
                outReg   <= skidReg;
                outValid <= 1'b1;
            end else if (reqValid) begin
                outReg   <= arrival;
                outValid <= 1'b1;
            end else begin
                outValid <= 1'b0;
            end
            skidValid <= 1'b0;
        end
    end

    assign instructionOut   = outReg.instr;
    assign pcOut            = outReg.pc;
    assign instructionValid = outValid;

endmodule

// File: tb/tb_jzjpcc_fetch_buffer.sv
// Bench for jzjpcc_fetch_buffer: PC/memory environment, queue model, directed and random stalls.
module tb_jzjpcc_fetch_buffer;

    localparam logic [29:0] RPC = 30'd0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] currentPC = '0;
    logic [31:0] instructionIn = '0;
    logic        decodeStall = 1'b0;
    logic        flush = 1'b0;
    logic        pcStall;
    logic [31:0] instructionOut;
    logic [29:0] pcOut;
    logic        instructionValid;

    int total = 0;
    int bad = 0;

    jzjpcc_fetch_buffer #(.RESET_PC(RPC)) dut (
        .clock(clock),
        .reset(reset),
        .currentPC(currentPC),
        .instructionIn(instructionIn),
        .decodeStall(decodeStall),
        .flush(flush),
        .pcStall(pcStall),
        .instructionOut(instructionOut),
        .pcOut(pcOut),
        .instructionValid(instructionValid)
    );

    always #5 clock = ~clock;

    // Model: queue of delivered-but-unconsumed fetches (head = IF/ID) plus one in-flight read
    logic [29:0] q[$];
    logic        fv = 1'b0;
    logic [29:0] fa = '0;
    logic        started = 1'b0;
    logic        haveLast = 1'b0;
    logic [29:0] last = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic rst, input logic ds, input logic fl,
                       input logic [29:0] tgt);
        logic        expStall;
        logic        stalled;
        logic [29:0] npc;
        logic [31:0] nmem;
        reset = rst;
        decodeStall = ds;
        flush = fl;
        #1;
        expStall = ds & (q.size() > 0) & ~fl;
        if (started) begin
            chk("valid", {31'd0, instructionValid}, {31'd0, q.size() > 0});
            chk("pcStall", {31'd0, pcStall}, {31'd0, expStall});
            if (q.size() > 0) begin
                chk("pcOut", {2'b00, pcOut}, {2'b00, q[0]});
                chk("instr", instructionOut, {q[0], 2'b00});
            end
            if (!rst && !fl && instructionValid && !ds) begin
                if (haveLast) chk("seq", {2'b00, pcOut}, {2'b00, last + 30'd1});
                haveLast = 1'b1;
                last = pcOut;
            end
            if (rst || fl) haveLast = 1'b0;
        end
        if (rst) npc = RPC;
        else if (fl) npc = tgt;
        else if (!expStall) npc = currentPC + 30'd1;
        else npc = currentPC;
        nmem = {currentPC, 2'b00};
        if (rst || fl) begin
            q.delete();
            fv = 1'b0;
        end else begin
            stalled = ds && (q.size() > 0);
            if (!stalled && q.size() > 0) void'(q.pop_front());
            if (fv) begin
                chk("skid_ovf", {31'd0, q.size() < 2}, 32'd1);
                q.push_back(fa);
            end
            fv = ~expStall;
            fa = currentPC;
        end
        @(posedge clock);
        #1;
        if (rst) started = 1'b1;
        currentPC = npc;
        instructionIn = nmem;
    endtask

    initial begin
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("rst_valid", {31'd0, instructionValid}, 32'd0);
        chk("rst_pcOut", {2'b00, pcOut}, 32'd0);
        chk("rst_instr", instructionOut, 32'd0);
        chk("rst_pcStall", {31'd0, pcStall}, 32'd0);

        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("first_bubble", {31'd0, instructionValid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i <= 5; i++) begin
            chk("run_pc", {2'b00, pcOut}, i);
            chk("run_valid", {31'd0, instructionValid}, 32'd1);
            if (i < 5) cyc(1'b0, 1'b0, 1'b0, '0);
        end

        for (int i = 0; i < 3; i++) begin
            decodeStall = 1'b1;
            #1;
            chk("stall_pcStall", {31'd0, pcStall}, 32'd1);
            cyc(1'b0, 1'b1, 1'b0, '0);
        end
        chk("stall_hold", {2'b00, pcOut}, 32'd5);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("rel_pc6", {2'b00, pcOut}, 32'd6);
        chk("rel_instr6", instructionOut, 32'h18);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("rel_pc7", {2'b00, pcOut}, 32'd7);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("pc8", {2'b00, pcOut}, 32'd8);

        cyc(1'b0, 1'b0, 1'b1, 30'h40);
        chk("fl_bub1", {31'd0, instructionValid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("fl_bub2", {31'd0, instructionValid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("fl_pc40", {2'b00, pcOut}, 32'h40);
        chk("fl_v40", {31'd0, instructionValid}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("fl_pc41", {2'b00, pcOut}, 32'h41);

        cyc(1'b0, 1'b1, 1'b0, '0);
        decodeStall = 1'b1;
        flush = 1'b1;
        #1;
        chk("flst_pcStall", {31'd0, pcStall}, 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 30'h80);
        chk("flst_valid", {31'd0, instructionValid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("flst_skid_gone", {31'd0, instructionValid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("flst_pc80", {2'b00, pcOut}, 32'h80);

        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, 1'b0, '0);
        chk("rstk_valid", {31'd0, instructionValid}, 32'd0);
        chk("rstk_pcStall", {31'd0, pcStall}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("rstk_bubble", {31'd0, instructionValid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("rstk_restart", {2'b00, pcOut}, {2'b00, RPC});
        chk("rstk_v", {31'd0, instructionValid}, 32'd1);

        for (int i = 0; i < 1000; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
